instr_mem_loader: RTL
=====================

# instr_mem_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, packs every four bytes little-endian into a 32-bit instruction, and issues one word write per instruction into the instruction memory write port. Writes start at byte address 0 and use consecutive word addresses. While loading, it holds the core in reset so the fetch path never reads a half-written program.

## Interface

Parameters:
- MEM_DEPTH_POW, 10, log2 of instruction-memory depth in words; must match the instruction memory
- ADDR_WIDTH, 64, byte-address width of the write port (fixed)
- DATA_WIDTH, 32, instruction width (fixed)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start_in  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE
- word_count_in  input  MEM_DEPTH_POW+1  number of words to load; sampled with start_in
- byte_data_in  input  8  stream byte
- byte_valid_in  input  1  byte_data_in is valid
- byte_ready_out  output  1  loader accepts a byte this cycle
- mem_we_out  output  1  word write strobe, one cycle per word
- mem_addr_out  output  ADDR_WIDTH  byte address of the write, always word-aligned
- mem_data_out  output  DATA_WIDTH  instruction word to write
- busy_out  output  1  high in LOAD
- done_out  output  1  sticky completion flag
- err_out  output  1  sticky flag: word_count_in exceeded MEM_DEPTH and was clamped
- cpu_hold_out  output  1  keeps the core in reset; high in LOAD and from reset until the first DONE

## Operation

- States: IDLE, LOAD, DONE.
- Reset:
  - State goes to IDLE.
  - byte_ready_out, mem_we_out, busy_out, done_out and err_out are 0.
  - mem_addr_out and mem_data_out are 0.
  - cpu_hold_out is 1.
  - Byte lane counter, word counter and assembly register are cleared.
- IDLE or DONE with start_in=1:
  - Latch target = min(word_count_in, MEM_DEPTH).
  - Set err_out=1 if word_count_in > MEM_DEPTH; otherwise set err_out=0.
  - Clear done_out, lane counter and word counter.
  - If target=0: go to DONE and set done_out=1 on the next cycle. No writes occur.
  - If target>0: go to LOAD.
- LOAD:
  - byte_ready_out=1. A byte is accepted on any cycle with byte_valid_in && byte_ready_out.
  - The accepted byte goes into lane k (bits 8k+7:8k), where k is the lane counter (0..3). The lane counter wraps 3 to 0.
  - Accepting lane 3 completes the word.
  - On the next cycle: mem_we_out=1, mem_data_out holds the assembled word, and mem_addr_out = word_counter << 2 (zero-extended to 64 bits). The word counter then increments.
  - Byte acceptance continues during the write cycle, so there are no bubbles.
  - After the write for word target-1, the loader goes to DONE in the same cycle that mem_we_out is high.
  - byte_ready_out drops to 0 after the final lane-3 byte is accepted. No further bytes are taken.
- DONE:
  - done_out=1, cpu_hold_out=0, byte_ready_out=0.
  - The loader remains in DONE until reset or start_in.
- start_in during LOAD is ignored.
- byte_valid_in outside LOAD is ignored.
- Reset mid-load:
  - The partial word is discarded and no write is issued.
  - Words already written remain in memory.
  - cpu_hold_out returns to 1.
- Word counter width is MEM_DEPTH_POW+1. The top address written is (MEM_DEPTH-1)<<2. Address never wraps.

## Timing

- byte_ready_out is a registered function of state. It never depends combinationally on byte_valid_in.
- Latency: lane-3 byte accepted in cycle N gives mem_we_out=1 in cycle N+1.
- mem_addr_out and mem_data_out are stable for the whole cycle mem_we_out is high. Outside write cycles they hold their last values.
- Peak throughput: one word per 4 cycles with byte_valid_in held high.
- busy_out falls, and done_out and cpu_hold_out change, in the cycle after the final write cycle.
- start_in to busy_out=1 takes 1 cycle. The first byte can be accepted in that same first LOAD cycle.

## Test plan

- **Reset values:** assert reset for 2 cycles with random inputs -> all outputs 0 except cpu_hold_out=1. Then hold start_in=0 for 10 cycles -> state stays IDLE, no mem_we_out.
- **Two-word continuous load:** start_in with word_count_in=2, then bytes 0x13,0x05,0x10,0x00,0x93,0x05,0x20,0x00 on consecutive cycles -> the cycle after the 4th accepted byte (cycle N+1) shows a write of 0x00100513 to address 0x0; cycle N+5 shows a write of 0x00200593 to address 0x4; done_out=1 and cpu_hold_out=0 on the following cycle; exactly 2 writes in total.
- **Stalled source:** word_count_in=1 with byte_valid_in toggled on alternate cycles over bytes 0xEF,0xBE,0xAD,0xDE -> a single write of 0xDEADBEEF to address 0x0. No byte is dropped or duplicated.
- **Zero and overflow counts:**
  - word_count_in=0 -> done_out=1 one cycle later, zero writes.
  - With MEM_DEPTH_POW=2, word_count_in=7 -> err_out=1, exactly 4 writes to addresses 0x0,0x4,0x8,0xC.
- **Reset mid-word:** word_count_in=2, 6 bytes sent, reset asserted -> one write only (word 0). No write for the partial word. Post-reset values match the reset-values scenario.
- **Restart and ignored start:**
  - start_in pulsed during LOAD -> no effect on the counters.
  - After DONE, a new start_in with word_count_in=1 -> done_out clears, one write to address 0x0, done_out sets again.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into
// 32-bit words, writes them to consecutive addresses and holds the core meanwhile.
module instr_mem_loader #(
  parameter int MEM_DEPTH_POW = 10,
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_in,
  input  logic [MEM_DEPTH_POW:0]  word_count_in,
  input  logic [7:0]              byte_data_in,
  input  logic                    byte_valid_in,
  output logic                    byte_ready_out,
  output logic                    mem_we_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    err_out,
  output logic                    cpu_hold_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [MEM_DEPTH_POW:0] MEM_DEPTH = {1'b1, {MEM_DEPTH_POW{1'b0}}};
  localparam logic [MEM_DEPTH_POW:0] CNT_ONE   = {{MEM_DEPTH_POW{1'b0}}, 1'b1};
  localparam logic [MEM_DEPTH_POW:0] CNT_ZERO  = {(MEM_DEPTH_POW+1){1'b0}};

  state_t                  state_r, state_s;
  logic [1:0]              lane_r;
  logic [MEM_DEPTH_POW:0]  word_cnt_r, target_r, target_s;
  logic [23:0]             asm_r;
  logic                    ready_r, we_r, busy_r, done_r, err_r, hold_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    accept_s, lane3_s, last_byte_s, start_ok_s, over_s;
  logic                    ready_s, busy_s, done_s, hold_s;

  // Handshake qualifiers and clamped target for a new load
  always_comb begin
    accept_s   = byte_valid_in && ready_r;
    start_ok_s = start_in && (state_r != ST_LOAD);
    over_s     = (word_count_in > MEM_DEPTH);
    if (over_s) begin
      target_s = MEM_DEPTH;
    end else begin
      target_s = word_count_in;
    end
    lane3_s     = accept_s && (lane_r == 2'd3);
    // word_cnt_r still holds the index of the word being completed here
    last_byte_s = lane3_s && (word_cnt_r == (target_r - CNT_ONE));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; LOAD exits during the final write cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          if (target_s == CNT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (we_r && (word_cnt_r == target_r)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the state-derived status outputs
  always_comb begin
    ready_s = (state_s == ST_LOAD) && !last_byte_s;
    busy_s  = (state_s == ST_LOAD);
    done_s  = (state_s == ST_DONE);
    hold_s  = (state_s != ST_DONE);
  end

  // Registered outputs, byte assembly and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r    <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      hold_r     <= 1'b1;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      data_r     <= {DATA_WIDTH{1'b0}};
      lane_r     <= 2'd0;
      word_cnt_r <= CNT_ZERO;
      target_r   <= CNT_ZERO;
      asm_r      <= 24'd0;
    end else begin
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      hold_r  <= hold_s;
      we_r    <= lane3_s;
      if (start_ok_s) begin
        lane_r     <= 2'd0;
        word_cnt_r <= CNT_ZERO;
        target_r   <= target_s;
        err_r      <= over_s;
      end else if (accept_s) begin
        lane_r <= lane_r + 2'd1;
        case (lane_r)
          2'd0: asm_r[7:0]   <= byte_data_in;
          2'd1: asm_r[15:8]  <= byte_data_in;
          2'd2: asm_r[23:16] <= byte_data_in;
          2'd3: begin
            data_r     <= {byte_data_in, asm_r};
            addr_r     <= {{(ADDR_WIDTH-MEM_DEPTH_POW-3){1'b0}}, word_cnt_r, 2'b00};
            word_cnt_r <= word_cnt_r + CNT_ONE;
          end
          default: lane_r <= 2'd0;
        endcase
      end
    end
  end

  assign byte_ready_out = ready_r;
  assign mem_we_out     = we_r;
  assign mem_addr_out   = addr_r;
  assign mem_data_out   = data_r;
  assign busy_out       = busy_r;
  assign done_out       = done_r;
  assign err_out        = err_r;
  assign cpu_hold_out   = hold_r;

endmodule
